// File: rtl/bomberman_pkg.sv
// bomberman_pkg: move codes, pad button indices and the button-to-move encoder shared with the game FSM.
package bomberman_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4,
        BOMB  = 3'd5
    } move_t;

    typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} pad_state_t;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // Opposing directions fall out of the priority order: Up beats Down, Left beats Right.
    function automatic move_t encode_move(input logic [11:0] b);
        return (b[BTN_A] | b[BTN_B]) ? BOMB :
               b[BTN_UP]             ? UP   :
               b[BTN_DOWN]           ? DOWN :
               b[BTN_LEFT]           ? LEFT :
               b[BTN_RIGHT]          ? RIGHT : NONE;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer; resets to 1 so an unplugged or idle pad reads as released.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge reset)
        if (reset) {q, meta} <= 2'b11;
        else       {q, meta} <= {meta, d};

endmodule

// File: rtl/snes_pad_reader.sv
// snes_pad_reader: polls one SNES pad at a fixed rate and turns its button word into a move code and Start pulse.
module snes_pad_reader
    import bomberman_pkg::*;
#(
    parameter int HALF_CYC = 300,
    parameter int POLL_CYC = 833333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [11:0] buttons,
    output move_t       move,
    output logic        frame_valid,
    output logic        start_pulse
);
    localparam int PW = $clog2(POLL_CYC);
    localparam int HW = $clog2(2 * HALF_CYC);

    pad_state_t    state;
    logic [PW-1:0] poll;
    logic [HW-1:0] phase;
    logic [3:0]    idx;
    logic [11:0]   shift;
    logic          prev_start;
    logic          sd;
    logic          wrap;
    logic          half_end;

    sync2 u_sync (.clk(clk), .reset(reset), .d(pad_data), .q(sd));

    assign wrap     = poll == PW'(POLL_CYC - 1);
    assign half_end = phase == HW'(HALF_CYC - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) poll <= '0;
        else       poll <= wrap ? '0 : poll + 1'b1;

    // Samples shift in at the top so after twelve bits bit 0 holds B; bits 12-15 are never captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            idx         <= '0;
            shift       <= '0;
            prev_start  <= 1'b0;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b1;
            buttons     <= '0;
            move        <= NONE;
            frame_valid <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            case (state)
                IDLE: if (wrap) begin
                    state     <= LATCH;
                    pad_latch <= 1'b1;
                    phase     <= '0;
                end
                LATCH: if (phase == HW'(2 * HALF_CYC - 1)) begin
                    state     <= CLK_LO;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                    phase     <= '0;
                    idx       <= '0;
                end else phase <= phase + 1'b1;
                CLK_LO: if (half_end) begin
                    if (idx < 4'd12) shift <= {~sd, shift[11:1]};
                    state   <= CLK_HI;
                    pad_clk <= 1'b1;
                    phase   <= '0;
                end else phase <= phase + 1'b1;
                CLK_HI: if (half_end) begin
                    phase <= '0;
                    if (idx == 4'd15) begin
                        state       <= DONE;
                        buttons     <= shift;
                        move        <= encode_move(shift);
                        frame_valid <= 1'b1;
                        start_pulse <= shift[BTN_START] & ~prev_start;
                        prev_start  <= shift[BTN_START];
                    end else begin
                        state   <= CLK_LO;
                        pad_clk <= 1'b0;
                        idx     <= idx + 4'd1;
                    end
                end else phase <= phase + 1'b1;
                DONE: begin
                    state       <= IDLE;
                    frame_valid <= 1'b0;
                    start_pulse <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/snes_pad_reader.md
# snes_pad_reader

Polls one SNES-style serial gamepad at a fixed rate and converts the sampled button word into the 3-bit move code consumed by the game state machine's `p1_move` / `p2_move` inputs. It also produces a one-cycle `start_pulse` for the game state machine's `start` input. One instance is used per player, sitting between the board pins and the game state machine.

## Interface

**Decided:** one clock; reset is asynchronous and active-high.

Parameters:
- `HALF_CYC`, 300: clk cycles per pad_clk half-period (6 µs at 50 MHz). Must be ≥ 4.
- `POLL_CYC`, 833333: clk cycles between frame starts (60 Hz). Must be > 34·HALF_CYC + 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `pad_data` in 1: serial data from the pad, active-low, asynchronous.
- `pad_latch` out 1: latch strobe to the pad.
- `pad_clk` out 1: shift clock to the pad; idles high.
- `buttons` out 12: active-high button state from the last complete frame.
- `move` out 3: `move_t` code derived from `buttons`.
- `frame_valid` out 1: one-cycle pulse when `buttons` and `move` update.
- `start_pulse` out 1: one-cycle pulse on a released→pressed transition of Start.

## Operation

- `pad_data` passes through a 2-flop synchronizer before any use.
- Free-running poll counter counts 0..POLL_CYC−1 and wraps. A frame starts on the wrap.
- FSM states: IDLE, LATCH, CLK_LO, CLK_HI, DONE.
  - **IDLE:** `pad_latch`=0, `pad_clk`=1. On poll wrap → LATCH.
  - **LATCH:** `pad_latch`=1 for 2·HALF_CYC cycles → CLK_LO, bit index 0.
  - **CLK_LO:** `pad_clk`=0 for HALF_CYC cycles. On the last cycle, shift register bit[index] ← ~synced `pad_data`. Then → CLK_HI.
  - **CLK_HI:** `pad_clk`=1 for HALF_CYC cycles. If index = 15 → DONE; otherwise increment index and → CLK_LO.
  - **DONE:** one cycle. Copy shift bits 11:0 to `buttons`, update `move`, pulse `frame_valid`, evaluate `start_pulse`. Then → IDLE. Bits 12–15 are discarded.
- Button indices: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R.
- Move priority:
  - BOMB if A or B is pressed;
  - else UP, DOWN, LEFT, RIGHT, in that order;
  - else NONE.
  - Opposing directions resolve by this priority: Up+Down → UP, Left+Right → LEFT.
- `start_pulse`: asserted in DONE if new Start = 1 and the previous frame's Start = 0.

## Timing

- Reset values: `pad_latch`=0, `pad_clk`=1, `buttons`=0, `move`=NONE, `frame_valid`=0, `start_pulse`=0, FSM=IDLE, poll counter=0, previous Start=0.
- First `pad_latch` rise occurs on the cycle after the poll counter wraps, i.e. POLL_CYC cycles after reset deassertion. Later frames start every POLL_CYC cycles thereafter.
- Frame length from `pad_latch` rise to the `frame_valid` cycle: 34·HALF_CYC cycles, with `frame_valid` on cycle 34·HALF_CYC+1.
- Outputs are registered. `buttons` and `move` change in the same cycle `frame_valid` is high and hold until the next DONE.
- Sampled data lags the pad by 2 cycles (synchronizer). HALF_CYC ≥ 4 guarantees the data has settled.
- Reset mid-frame aborts immediately:
  - all outputs return to reset values;
  - the partial frame is discarded and no `frame_valid` is produced.

## Structure

- Shared package `bomberman_pkg`:
  - `move_t` enum: NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, BOMB=5.
  - Button index constants `BTN_B` … `BTN_R`.
  - The game state machine imports the same `move_t`.
- One sub-module, `sync2`: 2-flop synchronizer, async active-high reset, reset value 1 (pad released).
- Everything else (FSM, poll counter, phase counter, bit counter, shift register, move encoder) lives in `snes_pad_reader`.

## Test plan

Bench configuration: HALF_CYC=4, POLL_CYC=200, behavioural pad model.

1. **Reset and idle:** hold reset, release → all reset values hold. First `pad_latch` rise occurs 200 cycles after release.
2. **Waveform:** per frame, `pad_latch` is high for exactly 8 cycles, followed by 16 `pad_clk` low pulses of 4 cycles each, separated by 4-cycle highs. `frame_valid` pulses once, on cycle 137 after the latch rise.
3. **Up pressed** (pad drives bit 4 low) → `buttons`=12'h010, `move`=UP.
4. **Up + A pressed** → `buttons`=12'h110, `move`=BOMB. **Left + Right pressed** → `move`=LEFT.
5. **Start held across 3 frames** → exactly one `start_pulse`, on the first DONE. Release for one frame, then press again → a second pulse.
6. **Reset asserted during bit 7's CLK_LO** → `pad_clk`=1, `pad_latch`=0 and `buttons`=0 immediately, with no `frame_valid`. The next frame starts 200 cycles after release.
